// File: rtl/splitter_pkg.sv
// Shared field widths, bit positions, opcode constants and the decoded-field payload for the MIPS instruction splitter.
package splitter_pkg;

    localparam int unsigned INSTR_W  = 32;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned SHAMT_W  = 5;
    localparam int unsigned FUNC_W   = 6;
    localparam int unsigned IMM_W    = 16;
    localparam int unsigned ADDR_W   = 26;
    localparam int unsigned ITYPE_W  = 2;

    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned SHAMT_LSB = 6;
    localparam int unsigned FUNC_LSB  = 0;
    localparam int unsigned IMM_LSB   = 0;
    localparam int unsigned ADDR_LSB  = 0;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;

    typedef enum logic [ITYPE_W-1:0] {
        ITYPE_R   = 2'd0,
        ITYPE_I   = 2'd1,
        ITYPE_J   = 2'd2,
        ITYPE_NOP = 2'd3
    } itype_e;

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [REG_W-1:0]   rs;
        logic [REG_W-1:0]   rt;
        logic [REG_W-1:0]   rd;
        logic [SHAMT_W-1:0] shamt;
        logic [FUNC_W-1:0]  func;
        logic [IMM_W-1:0]   imm16;
        logic [ADDR_W-1:0]  addr26;
        logic [INSTR_W-1:0] imm32s;
        logic [INSTR_W-1:0] imm32z;
        logic [INSTR_W-1:0] imm32lui;
        itype_e             itype;
    } fields_t;

endpackage

// File: rtl/splitter_fields.sv
// Combinational slicer: breaks one instruction word into every field, immediate extension and format class.
module splitter_fields
    import splitter_pkg::*;
(
    input  logic [INSTR_W-1:0] word,
    output fields_t            fields
);

    logic [IMM_W-1:0] imm;

    assign imm = word[IMM_LSB +: IMM_W];

    always_comb begin
        fields          = '0;
        fields.op       = word[OP_LSB    +: OP_W];
        fields.rs       = word[RS_LSB    +: REG_W];
        fields.rt       = word[RT_LSB    +: REG_W];
        fields.rd       = word[RD_LSB    +: REG_W];
        fields.shamt    = word[SHAMT_LSB +: SHAMT_W];
        fields.func     = word[FUNC_LSB  +: FUNC_W];
        fields.imm16    = imm;
        fields.addr26   = word[ADDR_LSB  +: ADDR_W];
        fields.imm32s   = {{(INSTR_W-IMM_W){imm[IMM_W-1]}}, imm};
        fields.imm32z   = {{(INSTR_W-IMM_W){1'b0}}, imm};
        fields.imm32lui = {imm, {(INSTR_W-IMM_W){1'b0}}};

        // All-zero word is the canonical NOP and wins over the R-type opcode match.
        if (word == '0) begin
            fields.itype = ITYPE_NOP;
        end else if (fields.op == OP_RTYPE) begin
            fields.itype = ITYPE_R;
        end else if (fields.op == OP_J || fields.op == OP_JAL) begin
            fields.itype = ITYPE_J;
        end else begin
            fields.itype = ITYPE_I;
        end
    end

endmodule

// File: rtl/splitter.sv
// Registered instruction-field splitter: captures Instr on in_valid and presents decoded fields one cycle later.
module splitter
    import splitter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [INSTR_W-1:0]   Instr,
    output logic                 out_valid,
    output logic [OP_W-1:0]      Op,
    output logic [REG_W-1:0]     Rs,
    output logic [REG_W-1:0]     Rt,
    output logic [REG_W-1:0]     Rd,
    output logic [SHAMT_W-1:0]   Shamt,
    output logic [FUNC_W-1:0]    func,
    output logic [IMM_W-1:0]     Imm16,
    output logic [ADDR_W-1:0]    Addr26,
    output logic [INSTR_W-1:0]   Imm32S,
    output logic [INSTR_W-1:0]   Imm32Z,
    output logic [INSTR_W-1:0]   Imm32Lui,
    output logic [ITYPE_W-1:0]   IType
);

    logic [INSTR_W-1:0] instr_q;
    logic               valid_q;
    fields_t            fields;

    // Instruction register holds its last capture while in_valid is low; valid tracks in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                instr_q <= Instr;
            end
        end
    end

    splitter_fields u_fields (
        .word   (instr_q),
        .fields (fields)
    );

    assign out_valid = valid_q;
    assign Op        = fields.op;
    assign Rs        = fields.rs;
    assign Rt        = fields.rt;
    assign Rd        = fields.rd;
    assign Shamt     = fields.shamt;
    assign func      = fields.func;
    assign Imm16     = fields.imm16;
    assign Addr26    = fields.addr26;
    assign Imm32S    = fields.imm32s;
    assign Imm32Z    = fields.imm32z;
    assign Imm32Lui  = fields.imm32lui;
    assign IType     = ITYPE_W'(fields.itype);

endmodule

// File: tb/tb_splitter.sv
// Self-checking bench for splitter: directed vectors plus randomized traffic against an arithmetic reference model.
module tb_splitter;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] Instr;
    logic        out_valid;
    logic [5:0]  Op;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [4:0]  Shamt;
    logic [5:0]  func;
    logic [15:0] Imm16;
    logic [25:0] Addr26;
    logic [31:0] Imm32S;
    logic [31:0] Imm32Z;
    logic [31:0] Imm32Lui;
    logic [1:0]  IType;

    int unsigned n_checks;
    int unsigned n_fail;

    // Reference state: the word the DUT should be holding and whether it is valid.
    logic [31:0] ref_word;
    logic        ref_valid;

    splitter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .Instr     (Instr),
        .out_valid (out_valid),
        .Op        (Op),
        .Rs        (Rs),
        .Rt        (Rt),
        .Rd        (Rd),
        .Shamt     (Shamt),
        .func      (func),
        .Imm16     (Imm16),
        .Addr26    (Addr26),
        .Imm32S    (Imm32S),
        .Imm32Z    (Imm32Z),
        .Imm32Lui  (Imm32Lui),
        .IType     (IType)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected fields computed with divide/modulo arithmetic from the held word.
    task automatic check_model(input string tag);
        int unsigned w;
        int unsigned op, imm, itype;
        w   = ref_word;
        op  = w / 32'h0400_0000;
        imm = w % 32'h0001_0000;
        if (w == 0)                 itype = 3;
        else if (op == 0)           itype = 0;
        else if (op == 2 || op == 3) itype = 2;
        else                        itype = 1;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(ref_valid));
        check({tag, ".Op"},       32'(Op),       op);
        check({tag, ".Rs"},       32'(Rs),       (w / 32'h0020_0000) % 32);
        check({tag, ".Rt"},       32'(Rt),       (w / 32'h0001_0000) % 32);
        check({tag, ".Rd"},       32'(Rd),       (w / 32'h0000_0800) % 32);
        check({tag, ".Shamt"},    32'(Shamt),    (w / 64) % 32);
        check({tag, ".func"},     32'(func),     w % 64);
        check({tag, ".Imm16"},    32'(Imm16),    imm);
        check({tag, ".Addr26"},   32'(Addr26),   w % 32'h0400_0000);
        check({tag, ".Imm32S"},   Imm32S,        (imm >= 32'h8000) ? (imm + 32'hFFFF_0000) : imm);
        check({tag, ".Imm32Z"},   Imm32Z,        imm);
        check({tag, ".Imm32Lui"}, Imm32Lui,      imm * 32'h0001_0000);
        check({tag, ".IType"},    32'(IType),    itype);
    endtask

    // Drive one cycle's inputs at the falling edge, then check just after the rising edge.
    task automatic step(input logic v, input logic [31:0] w, input string tag);
        @(negedge clk);
        in_valid = v;
        Instr    = w;
        @(posedge clk);
        if (v) ref_word = w;
        ref_valid = v;
        #1;
        check_model(tag);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int unsigned sel;
        w   = $urandom;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       w = 32'h0;
            1:       w = {6'h00, w[25:0]};
            2:       w = {6'h02, w[25:0]};
            3:       w = {6'h03, w[25:0]};
            4:       w = {w[31:16], 1'b1, w[14:0]};
            default: ;
        endcase
        return w;
    endfunction

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        Instr     = 32'hDEAD_BEEF;
        ref_word  = 32'h0;
        ref_valid = 1'b0;

        // Asynchronous reset is visible before any clock edge.
        #1;
        check_model("reset");
        check("reset.IType_nop", 32'(IType), 32'd3);

        @(negedge clk);
        rst_n = 1'b1;

        step(1'b1, 32'h3401_3456, "ori1");
        check("ori1.Rd",       32'(Rd),    32'd6);
        check("ori1.Shamt",    32'(Shamt), 32'd17);
        check("ori1.func",     32'(func),  32'h16);
        check("ori1.Imm32Lui", Imm32Lui,   32'h3456_0000);
        step(1'b1, 32'h340B_1234, "ori2");
        check("ori2.Rt",       32'(Rt),    32'h0B);
        step(1'b1, 32'hAC85_FFFF, "sw");
        check("sw.Imm32S",     Imm32S,     32'hFFFF_FFFF);
        check("sw.Addr26",     32'(Addr26), 32'h085_FFFF);
        step(1'b0, 32'h1234_5678, "hold1");
        check("hold1.Imm32Z",  Imm32Z,     32'h0000_FFFF);
        step(1'b0, 32'hFFFF_FFFF, "hold2");
        step(1'b1, 32'h0000_0000, "nop");
        check("nop.IType",     32'(IType), 32'd3);
        step(1'b1, 32'h0C00_0010, "jal");
        check("jal.IType",     32'(IType), 32'd2);
        step(1'b1, 32'h0109_5020, "add");
        check("add.IType",     32'(IType), 32'd0);
        check("add.Rd",        32'(Rd),    32'd10);

        // Mid-cycle asynchronous reset clears everything and blocks capture while held.
        #2;
        rst_n     = 1'b0;
        ref_word  = 32'h0;
        ref_valid = 1'b0;
        #1;
        check_model("async_rst");
        in_valid = 1'b1;
        Instr    = 32'h2108_0001;
        @(posedge clk);
        #1;
        check_model("rst_held");
        @(negedge clk);
        rst_n    = 1'b1;
        step(1'b1, 32'h2108_0001, "post_rst");

        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, rand_instr(), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
